// File: rtl/hack_data_mem_if.sv
// Hack CPU data-memory port plus the TX stream and keyboard pins, bundled for the data-memory responder.
interface hack_data_mem_if;
   logic [15:0] addressM;
   logic        writeM;
   logic [15:0] outM;
   logic [15:0] inM;
   logic [15:0] tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [15:0] kbd_data;
   logic        kbd_strobe;

   modport slave (
      input  addressM, writeM, outM, tx_ready, kbd_data, kbd_strobe,
      output inM, tx_data, tx_valid
   );

   modport master (
      output addressM, writeM, outM, tx_ready, kbd_data, kbd_strobe,
      input  inM, tx_data, tx_valid
   );
endinterface

// File: rtl/hack_data_mem.sv
// Hack data memory: word RAM plus an I/O window (TX FIFO, status, keyboard latch, cycle counter).
// Writes are two-phase because the CPU presents outM one cycle after writeM.
module hack_data_mem #(
   parameter int          ADDR_W     = 14,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [15:0] IO_BASE    = 16'h6000
) (
   input  logic           clk,
   input  logic           reset,
   hack_data_mem_if.slave bus
);
   localparam int DATA_W = 16;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
   localparam logic [15:0]      TX_ADDR   = IO_BASE;
   localparam logic [15:0]      STAT_ADDR = IO_BASE + 16'd1;
   localparam logic [15:0]      KBD_ADDR  = IO_BASE + 16'd2;
   localparam logic [15:0]      CNT_ADDR  = IO_BASE + 16'd3;

   function automatic logic in_ram(input logic [15:0] a);
      return (a >> ADDR_W) == 16'd0;
   endfunction

   logic              pend_valid;
   logic [15:0]       pend_addr;
   logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
   logic [DATA_W-1:0] fifo_mem [0:FIFO_DEPTH-1];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              overflow;
   logic              kbd_valid;
   logic [DATA_W-1:0] kbd_code;
   logic [DATA_W-1:0] cycle_cnt;

   logic commit_ram, commit_tx, commit_stat, commit_kbd, commit_cnt;
   logic full, empty, pop, push_ok, fwd;
   logic [DATA_W-1:0] rd_data;

   // Commit decode: the address was latched last edge, the data arrives now on outM.
   assign commit_ram  = pend_valid && in_ram(pend_addr);
   assign commit_tx   = pend_valid && (pend_addr == TX_ADDR);
   assign commit_stat = pend_valid && (pend_addr == STAT_ADDR);
   assign commit_kbd  = pend_valid && (pend_addr == KBD_ADDR);
   assign commit_cnt  = pend_valid && (pend_addr == CNT_ADDR);

   assign full    = (count == DEPTH_C);
   assign empty   = (count == '0);
   assign pop     = !empty && bus.tx_ready;
   // A pop on the same edge frees the head slot, so a full FIFO still accepts.
   assign push_ok = commit_tx && (!full || pop);

   assign bus.tx_valid = !empty;
   assign bus.tx_data  = empty ? '0 : fifo_mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_valid <= 1'b0;
         pend_addr  <= '0;
      end else begin
         pend_valid <= bus.writeM;
         pend_addr  <= bus.addressM;
      end
   end

   // RAM and FIFO storage are not reset; every write is gated by pend_valid, which is.
   always_ff @(posedge clk) begin
      if (commit_ram)
         ram[pend_addr[ADDR_W-1:0]] <= bus.outM;
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         fifo_mem[wr_ptr] <= bus.outM;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (commit_tx && !push_ok)
            overflow <= 1'b1;
         else if (commit_stat)
            overflow <= 1'b0;
      end
   end

   // Capture takes priority over a clear committing on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         kbd_valid <= 1'b0;
         kbd_code  <= '0;
      end else if (bus.kbd_strobe) begin
         kbd_valid <= 1'b1;
         kbd_code  <= bus.kbd_data;
      end else if (commit_kbd) begin
         kbd_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cycle_cnt <= '0;
      else if (commit_cnt)
         cycle_cnt <= bus.outM;
      else
         cycle_cnt <= cycle_cnt + 16'd1;
   end

   // Read path: only RAM hits are forwarded; I/O reads show pre-commit state.
   assign fwd = pend_valid && (pend_addr == bus.addressM) && in_ram(bus.addressM);

   always_comb begin
      rd_data = '0;
      if (in_ram(bus.addressM)) begin
         rd_data = fwd ? bus.outM : ram[bus.addressM[ADDR_W-1:0]];
      end else begin
         case (bus.addressM)
            TX_ADDR:   rd_data = {{(DATA_W-CNT_W){1'b0}}, count};
            STAT_ADDR: rd_data = {12'd0, overflow, kbd_valid, empty, full};
            KBD_ADDR:  rd_data = kbd_code;
            CNT_ADDR:  rd_data = cycle_cnt;
            default:   rd_data = '0;
         endcase
      end
   end

   assign bus.inM = rd_data;
endmodule

// File: tb/tb_hack_data_mem.sv
// Directed bench for hack_data_mem: table of write/read vectors plus hand-built multi-cycle sequences.
module tb_hack_data_mem;
   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_bad = 0;

   hack_data_mem_if bus();

   hack_data_mem #(.ADDR_W(14), .FIFO_DEPTH(4), .IO_BASE(16'h6000)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        do_wr;
      logic [15:0] wa;
      logic [15:0] wd;
      logic [15:0] ra;
      logic [15:0] exp;
   } vec_t;

   vec_t        vecs [9];
   logic [15:0] drain_exp [4];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input string name, input logic [15:0] a, input logic [15:0] exp);
      bus.addressM = a;
      #1;
      check(name, bus.inM, exp);
   endtask

   // CPU-style write: address with writeM this cycle, data on outM the next.
   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      bus.addressM = a;
      bus.writeM   = 1'b1;
      tick();
      bus.writeM   = 1'b0;
      bus.outM     = d;
      tick();
   endtask

   initial begin
      vecs[0] = '{1'b1, 16'h0000, 16'hAAAA, 16'h0000, 16'hAAAA};
      vecs[1] = '{1'b1, 16'h3FFF, 16'h5555, 16'h3FFF, 16'h5555};
      vecs[2] = '{1'b1, 16'h4000, 16'h2222, 16'h4000, 16'h0000};
      vecs[3] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 16'hAAAA};
      vecs[4] = '{1'b1, 16'h6005, 16'h1111, 16'h6005, 16'h0000};
      vecs[5] = '{1'b0, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000};
      vecs[6] = '{1'b1, 16'h0001, 16'h0001, 16'h0001, 16'h0001};
      vecs[7] = '{1'b0, 16'h0000, 16'h0000, 16'h6000, 16'h0000};
      vecs[8] = '{1'b0, 16'h0000, 16'h0000, 16'h6001, 16'h0002};
      drain_exp[0] = 16'd11;
      drain_exp[1] = 16'd12;
      drain_exp[2] = 16'd13;
      drain_exp[3] = 16'd14;

      reset          = 1'b1;
      bus.addressM   = '0;
      bus.writeM     = 1'b0;
      bus.outM       = '0;
      bus.tx_ready   = 1'b0;
      bus.kbd_data   = '0;
      bus.kbd_strobe = 1'b0;
      tick();
      tick();
      check("rst_tx_valid", {15'd0, bus.tx_valid}, 16'd0);
      check("rst_tx_data", bus.tx_data, 16'd0);
      rd("rst_status", 16'h6001, 16'h0002);
      rd("rst_cnt", 16'h6003, 16'h0000);
      rd("rst_kbd", 16'h6002, 16'h0000);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 9; i++) begin
         if (vecs[i].do_wr)
            wr(vecs[i].wa, vecs[i].wd);
         rd($sformatf("vec%0d", i), vecs[i].ra, vecs[i].exp);
         tick();
      end

      // Forwarding on RAM 5, neighbour 6 keeps its contents
      wr(16'h0006, 16'h0BAD);
      bus.addressM = 16'h0005;
      bus.writeM   = 1'b1;
      tick();
      bus.writeM   = 1'b0;
      bus.outM     = 16'h1234;
      rd("fwd_ram5", 16'h0005, 16'h1234);
      tick();
      bus.outM = 16'h0000;
      rd("commit_ram5", 16'h0005, 16'h1234);
      rd("ram6_old", 16'h0006, 16'h0BAD);
      tick();

      // Back-to-back pipelined writes to 8 and 9
      bus.addressM = 16'h0008;
      bus.writeM   = 1'b1;
      tick();
      bus.addressM = 16'h0009;
      bus.outM     = 16'h0008;
      tick();
      bus.writeM = 1'b0;
      bus.outM   = 16'h0009;
      rd("b2b_ram8", 16'h0008, 16'h0008);
      rd("b2b_fwd9", 16'h0009, 16'h0009);
      tick();
      bus.outM = 16'h0000;
      rd("b2b_ram9", 16'h0009, 16'h0009);

      // FIFO overflow then drain
      for (int i = 1; i <= 5; i++)
         wr(16'h6000, 16'(i));
      rd("ovf_count", 16'h6000, 16'd4);
      rd("ovf_status", 16'h6001, 16'h0009);
      wr(16'h6001, 16'h0000);
      rd("ovf_cleared", 16'h6001, 16'h0001);
      bus.tx_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         check($sformatf("drain_valid%0d", i), {15'd0, bus.tx_valid}, 16'd1);
         check($sformatf("drain_data%0d", i), bus.tx_data, 16'(i));
         tick();
      end
      check("drained_valid", {15'd0, bus.tx_valid}, 16'd0);
      rd("drained_status", 16'h6001, 16'h0002);
      bus.tx_ready = 1'b0;

      // Full FIFO accepts a push when a pop lands on the commit edge
      for (int i = 10; i <= 13; i++)
         wr(16'h6000, 16'(i));
      bus.addressM = 16'h6000;
      bus.writeM   = 1'b1;
      tick();
      bus.writeM   = 1'b0;
      bus.outM     = 16'd14;
      bus.tx_ready = 1'b1;
      tick();
      bus.tx_ready = 1'b0;
      rd("fullpop_count", 16'h6000, 16'd4);
      rd("fullpop_status", 16'h6001, 16'h0001);
      bus.tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("fullpop_data%0d", i), bus.tx_data, drain_exp[i]);
         tick();
      end
      check("fullpop_empty", {15'd0, bus.tx_valid}, 16'd0);
      bus.tx_ready = 1'b0;

      // Keyboard capture, clear, and capture winning over a same-edge clear
      bus.kbd_data   = 16'h0041;
      bus.kbd_strobe = 1'b1;
      tick();
      bus.kbd_strobe = 1'b0;
      rd("kbd_code", 16'h6002, 16'h0041);
      rd("kbd_status", 16'h6001, 16'h0006);
      wr(16'h6002, 16'h0000);
      rd("kbd_clear", 16'h6001, 16'h0002);
      bus.addressM = 16'h6002;
      bus.writeM   = 1'b1;
      tick();
      bus.writeM     = 1'b0;
      bus.outM       = 16'h0000;
      bus.kbd_data   = 16'h0042;
      bus.kbd_strobe = 1'b1;
      tick();
      bus.kbd_strobe = 1'b0;
      rd("kbd_race_status", 16'h6001, 16'h0006);
      rd("kbd_race_code", 16'h6002, 16'h0042);

      // Counter load and wrap
      wr(16'h6003, 16'hFFFE);
      rd("cnt_load", 16'h6003, 16'hFFFE);
      tick();
      rd("cnt_inc", 16'h6003, 16'hFFFF);
      tick();
      rd("cnt_wrap", 16'h6003, 16'h0000);

      // Reset between writeM and commit discards the write
      wr(16'h6000, 16'h0077);
      check("pre_rst_valid", {15'd0, bus.tx_valid}, 16'd1);
      wr(16'h0007, 16'h1111);
      bus.addressM = 16'h0007;
      bus.writeM   = 1'b1;
      tick();
      bus.writeM = 1'b0;
      bus.outM   = 16'hBEEF;
      reset      = 1'b1;
      #1;
      check("mid_rst_valid", {15'd0, bus.tx_valid}, 16'd0);
      rd("mid_rst_cnt", 16'h6003, 16'h0000);
      tick();
      reset = 1'b0;
      rd("rst_discard_ram7", 16'h0007, 16'h1111);
      check("post_rst_valid", {15'd0, bus.tx_valid}, 16'd0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/hack_data_mem.md
# hack_data_mem

Data-memory responder for the Hack CPU's M port: services `addressM`/`writeM`/`outM` and returns `inM`, giving the CPU a word-addressed RAM plus a small memory-mapped I/O window. The I/O window contains a transmit FIFO drained by a valid/ready stream, a latched keyboard input register, and a free-running cycle counter. The block sits beside the CPU in the top level, opposite the instruction ROM.

## Interface

- `ADDR_W`, 14: RAM holds 2^ADDR_W 16-bit words at addresses 0..2^ADDR_W-1; 2^ADDR_W must not exceed IO_BASE.
- `FIFO_DEPTH`, 4: TX FIFO entries; power of two, 2..16.
- `IO_BASE`, 16'h6000: base address of the I/O window.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `addressM`  in  16  CPU data address, valid in the current cycle.
- `writeM`  in  1  CPU write request for `addressM`, current cycle.
- `outM`  in  16  CPU write data; registered in the CPU, so it is valid one cycle after `writeM`.
- `inM`  out  16  read data for `addressM`, combinational, same cycle.
- `tx_data`  out  16  FIFO head word; 0 when the FIFO is empty.
- `tx_valid`  out  1  FIFO not empty.
- `tx_ready`  in  1  consumer accepts the head when high together with `tx_valid`.
- `kbd_data`  in  16  keyboard code.
- `kbd_strobe`  in  1  capture `kbd_data` this edge.

## Operation

- Address map:
  - RAM: 0..2^ADDR_W-1.
  - IO_BASE+0 TX: write pushes the word; read returns FIFO count.
  - IO_BASE+1 STATUS, read-only except bit3:
    - bit0: full.
    - bit1: empty.
    - bit2: kbd_valid.
    - bit3: overflow, sticky.
    - Any write clears overflow.
  - IO_BASE+2 KBD: read returns the latched code. Any write clears kbd_valid.
  - IO_BASE+3 CNT: read returns the counter. A write loads the counter with the written data.
  - All other addresses read 0, and writes to them are dropped.
- Reads have no side effects. `addressM` is always present, so read side effects are forbidden.
- Two-phase write:
  - At the edge where `writeM`=1, latch `pend_valid`=1 and `pend_addr`=`addressM`.
  - At the next edge, commit `outM` to `pend_addr`.
  - `pend_valid` reloads every edge from `writeM`, so back-to-back writes pipeline with no stall.
- RAM forwarding: when `pend_valid` is set and `pend_addr`==`addressM` (RAM range), `inM`=`outM`. Otherwise `inM` is the RAM word. I/O reads are not forwarded and return pre-commit state.
- FIFO pop and push:
  - Pop occurs when `tx_valid` && `tx_ready`.
  - A push commit is accepted if count<FIFO_DEPTH, or if a pop occurs on the same edge (full-with-pop: count unchanged).
  - Otherwise the word is dropped and overflow is set.
  - Push while empty: `tx_valid` rises after that edge.
  - Pointers wrap modulo FIFO_DEPTH. The count is a separate register of width log2(FIFO_DEPTH)+1.
- Keyboard:
  - `kbd_strobe` loads the latch and sets kbd_valid.
  - A new strobe overwrites an unread code.
  - If a strobe and a KBD clear commit on the same edge, the capture wins and kbd_valid stays 1.
- Counter: 16-bit, increments every edge and wraps 16'hFFFF→0. A CNT write commit loads the value W, which reads W in the following cycle and increments from there.

## Timing

- `inM` latency is 0 cycles (combinational). RAM read is asynchronous.
- A write is visible to a non-forwarded read 2 edges after the `writeM` cycle. With forwarding, it is visible from the cycle after `writeM`.
- Reset values:
  - Cleared: `pend_valid`, FIFO pointers and count, overflow, kbd_valid, kbd latch, counter.
  - Outputs: `tx_valid`=0, `tx_data`=0.
  - RAM contents are not reset.
  - `inM` follows the map combinationally.
- Reset asserted between the `writeM` cycle and the commit edge: the pending write is discarded and no RAM or I/O change occurs.
- `tx_data`/`tx_valid` are stable while `tx_valid`=1 and `tx_ready`=0.

## Test plan

- Write 16'h1234 to RAM 5, then read 5 on the next cycle (forwarded) and two cycles later → `inM`=16'h1234 both times. Read 6 → old contents.
- With `tx_ready`=0, write 1,2,3,4,5 to IO_BASE+0 → count 4, full=1, overflow=1. Then raise `tx_ready` → `tx_data` sequence 1,2,3,4, then `tx_valid`=0 and empty=1.
- With FIFO full and `tx_ready`=1, commit a push → count stays 4, overflow stays 0, and the new word emerges last.
- Assert `kbd_strobe` with 16'h0041 → KBD reads 16'h0041 and STATUS bit2=1. A write to KBD → bit2=0. A strobe on the same edge as a clear → bit2=1.
- Write 16'hFFFE to CNT → reads 16'hFFFE, then 16'hFFFF, then 16'h0000 on successive cycles.
- Assert `writeM` to RAM 7 with data 16'hBEEF, then assert `reset` before the commit edge → RAM 7 unchanged, `tx_valid`=0, counter=0.
